ex_stage: RTL and testbench

Execute stage of the 64-bit five-stage pipeline. It consumes the `ID_EX` pipeline-register outputs, performs single-cycle ALU operations, branch resolution and iterative 64-cycle multiply/divide, and drives the registered EX/MEM pipeline outputs. During a multi-cycle operation it asserts `ex_busy`, which freezes PC, IF/ID and ID/EX, and it inserts bubbles into EX/MEM.

---
 rtl/ex_stage.sv | 172 +++++++++++++++++
 tb/tb_ex_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 64-bit five-stage pipeline.
// Performs single-cycle ALU ops, branch resolution and iterative 64-cycle
// unsigned multiply / restoring divide, then registers the EX/MEM outputs.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ex_*                       ID/EX pipeline-register inputs
//   ex_busy                    combinational stall request (MUL/DIV in progress)
//   ex_branch_taken/_target    combinational branch resolution
//   mem_*                      registered EX/MEM outputs
module ex_stage #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] ex_pc_plus4,
    input  logic [4:0]      ex_rd,
    input  logic [5:0]      ex_funct,
    input  logic [15:0]     ex_imm16,
    input  logic [XLEN-1:0] ex_reg_data1,
    input  logic [XLEN-1:0] ex_reg_data2,
    input  logic            ex_reg_write,
    input  logic            ex_alu_src,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_mem_to_reg,
    input  logic            ex_branch,
    input  logic [2:0]      ex_alu_op,
    output logic            ex_busy,
    output logic            ex_branch_taken,
    output logic [XLEN-1:0] ex_branch_target,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            mem_mem_to_reg
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [5:0]      cnt;
    logic [XLEN-1:0] acc;     // multiply accumulator
    logic [XLEN-1:0] rem;     // divide partial remainder
    logic [XLEN-1:0] lo;      // multiplier (shifts right) / dividend->quotient (shifts left)
    logic [XLEN-1:0] opb_r;   // multiplicand (shifts left) / divisor (fixed)
    logic            is_div;
    logic            sel_rem;

    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic            md_start;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_sub;
    logic            rem_ge;
    logic [XLEN-1:0] md_res;

    always_comb begin
        imm      = {{(XLEN-16){ex_imm16[15]}}, ex_imm16};
        op_b     = ex_alu_src ? imm : ex_reg_data2;
        alu_res  = '0;
        case (ex_alu_op)
            3'b000: alu_res = ex_reg_data1 + op_b;
            3'b001: alu_res = ex_reg_data1 - op_b;
            3'b010: alu_res = ex_reg_data1 & op_b;
            3'b011: alu_res = ex_reg_data1 | op_b;
            3'b100: alu_res = ex_reg_data1 ^ op_b;
            3'b101: alu_res = {{(XLEN-1){1'b0}}, $signed(ex_reg_data1) < $signed(op_b)};
            default: alu_res = '0;
        endcase

        md_start = (state == S_IDLE) && (ex_alu_op[2:1] == 2'b11);
        ex_busy  = md_start || (state == S_RUN);

        ex_branch_taken  = ex_branch && (ex_reg_data1 == ex_reg_data2) && !ex_busy;
        ex_branch_target = ex_pc_plus4 + (imm << 2);

        // Restoring divide step: shift the next dividend bit into the remainder.
        // With a zero divisor every step subtracts 0, which naturally yields an
        // all-ones quotient and a remainder equal to the dividend.
        rem_sh  = {rem, lo[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, opb_r};
        rem_sub = rem_sh - {1'b0, opb_r};

        md_res = is_div ? (sel_rem ? rem : lo) : acc;

        state_nxt = state;
        case (state)
            S_IDLE:  if (md_start) state_nxt = S_RUN;
            S_RUN:   if (cnt == 6'd63) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            acc            <= '0;
            rem            <= '0;
            lo             <= '0;
            opb_r          <= '0;
            is_div         <= 1'b0;
            sel_rem        <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
        end else begin
            state <= state_nxt;

            // Bubble by default; the capture cases below override it.
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (md_start) begin
                        acc     <= '0;
                        rem     <= '0;
                        lo      <= ex_reg_data1;
                        opb_r   <= op_b;
                        is_div  <= ex_alu_op[0];
                        sel_rem <= ex_funct[0];
                        cnt     <= '0;
                    end else begin
                        mem_alu_result <= alu_res;
                        mem_store_data <= ex_reg_data2;
                        mem_rd         <= ex_rd;
                        mem_reg_write  <= ex_reg_write;
                        mem_mem_read   <= ex_mem_read;
                        mem_mem_write  <= ex_mem_write;
                        mem_mem_to_reg <= ex_mem_to_reg;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 6'd1;
                    if (is_div) begin
                        rem <= rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
                        lo  <= {lo[XLEN-2:0], rem_ge};
                    end else begin
                        if (lo[0]) acc <= acc + opb_r;
                        opb_r <= opb_r << 1;
                        lo    <= lo >> 1;
                    end
                end
                S_DONE: begin
                    mem_alu_result <= md_res;
                    mem_store_data <= ex_reg_data2;
                    mem_rd         <= ex_rd;
                    mem_reg_write  <= ex_reg_write;
                    mem_mem_read   <= ex_mem_read;
                    mem_mem_write  <= ex_mem_write;
                    mem_mem_to_reg <= ex_mem_to_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. Stimulus pushes expected
// EX/MEM contents into a queue; a monitor pops and compares whenever EX/MEM
// carries a non-bubble instruction.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ex_pc_plus4;
    logic [4:0]  ex_rd;
    logic [5:0]  ex_funct;
    logic [15:0] ex_imm16;
    logic [63:0] ex_reg_data1, ex_reg_data2;
    logic        ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [2:0]  ex_alu_op;
    logic        ex_busy, ex_branch_taken;
    logic [63:0] ex_branch_target, mem_alu_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;

    ex_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_pc_plus4(ex_pc_plus4), .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_imm16(ex_imm16),
        .ex_reg_data1(ex_reg_data1), .ex_reg_data2(ex_reg_data2),
        .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_alu_op(ex_alu_op),
        .ex_busy(ex_busy), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] store;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: any non-bubble EX/MEM content is a completed instruction.
    always @(negedge clk) begin
        if (mem_reg_write || mem_mem_read || mem_mem_write || mem_mem_to_reg) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got result %h rd %0d, expected no output",
                         mem_alu_result, mem_rd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check64("mem_alu_result", mem_alu_result, e.result);
                check64("mem_store_data", mem_store_data, e.store);
                check64("mem_rd", {59'd0, mem_rd}, {59'd0, e.rd});
            end
        end
    end

    task automatic set_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [15:0] imm, input logic src, input logic [4:0] rd,
                          input logic [5:0] funct);
        ex_alu_op     = op;
        ex_reg_data1  = a;
        ex_reg_data2  = b;
        ex_imm16      = imm;
        ex_alu_src    = src;
        ex_rd         = rd;
        ex_funct      = funct;
        ex_reg_write  = 1'b1;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
        ex_branch     = 1'b0;
        ex_pc_plus4   = 64'h0;
    endtask

    task automatic set_nop();
        set_op(3'b000, 64'd0, 64'd0, 16'd0, 1'b0, 5'd0, 6'd0);
        ex_reg_write = 1'b0;
    endtask

    // Push the expectation for the instruction currently on the inputs, then advance one edge.
    task automatic step_expect(input logic [63:0] res, input logic [63:0] store, input logic [4:0] rd);
        exp_t e;
        e.result = res;
        e.store  = store;
        e.rd     = rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [15:0] imm, input logic src, input logic [4:0] rd,
                       input logic [63:0] want);
        set_op(op, a, b, imm, src, rd, 6'd0);
        step_expect(want, b, rd);
    endtask

    // Multi-cycle op: busy must stay high exactly 65 cycles with bubbles on EX/MEM.
    task automatic muldiv(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] funct, input logic [4:0] rd, input logic [63:0] want);
        int busy_n = 0;
        bit bad = 0;
        bit done = 0;
        set_op(op, a, b, 16'd0, 1'b0, rd, funct);
        exp_q.push_back('{result: want, store: b, rd: rd});
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            // The first sample still shows the previous instruction's EX/MEM.
            if (c > 0 && (mem_reg_write || mem_mem_read || mem_mem_write || mem_mem_to_reg || mem_rd != 0))
                bad = 1;
            if (ex_busy) busy_n++;
            else done = 1;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL muldiv_timeout: busy still high after 200 cycles, expected release");
        end
        check64("busy_cycles", 64'(busy_n), 64'd65);
        check64("bubbles_during_run", {63'd0, bad}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random inputs: EX/MEM must be all zero.
        rst_n = 1'b0;
        set_op(3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom),
               1'($urandom), 5'($urandom), 6'($urandom));
        ex_mem_read = 1'b1; ex_mem_write = 1'b1; ex_mem_to_reg = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check64("reset_result", mem_alu_result, 64'd0);
        check64("reset_store", mem_store_data, 64'd0);
        check64("reset_ctrl", {54'd0, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-cycle ALU sweep, back to back.
        alu(3'b000, 64'd5, 64'd7, 16'd0, 1'b0, 5'd1, 64'd12);
        alu(3'b001, 64'd0, 64'd1, 16'd0, 1'b0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        alu(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 16'd0, 1'b0, 5'd3, 64'd1);
        alu(3'b101, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 1'b0, 5'd3, 64'd0);
        alu(3'b000, 64'd1000, 64'h0000_DEAD, 16'h8000, 1'b1, 5'd4, 64'hFFFF_FFFF_FFFF_83E8);
        alu(3'b010, 64'hF0F0_F0F0_0000_FFFF, 64'h0FF0_0FF0_FFFF_00FF, 16'd0, 1'b0, 5'd6, 64'h00F0_00F0_0000_00FF);
        alu(3'b011, 64'hF0F0_0000_0000_0001, 64'h0F0F_0000_0000_0010, 16'd0, 1'b0, 5'd7, 64'hFFFF_0000_0000_0011);
        alu(3'b100, 64'hFFFF_0000_1234_5678, 64'h00FF_FF00_1234_0000, 16'd0, 1'b0, 5'd8, 64'hFF00_FF00_0000_5678);
        alu(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 16'd0, 1'b0, 5'd9, 64'd1);

        // Multiply and back-to-back divides.
        muldiv(3'b110, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 6'd0, 5'd5, 64'hFFFF_FFFE_0000_0001);
        muldiv(3'b111, 64'd100, 64'd7, 6'd0, 5'd10, 64'd14);
        muldiv(3'b111, 64'd100, 64'd7, 6'd1, 5'd11, 64'd2);
        muldiv(3'b111, 64'd100, 64'd0, 6'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF);
        muldiv(3'b111, 64'd100, 64'd0, 6'd1, 5'd13, 64'd100);
        alu(3'b001, 64'd50, 64'd8, 16'd0, 1'b0, 5'd14, 64'd42);

        // Reset in the middle of a multiply.
        set_op(3'b110, 64'd123, 64'd456, 16'd0, 1'b0, 5'd15, 6'd0);
        repeat (31) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check64("midrun_reset_ctrl", {54'd0, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, 64'd0);
        check64("midrun_reset_result", mem_alu_result, 64'd0);
        rst_n = 1'b1;
        set_op(3'b000, 64'd3, 64'd4, 16'd0, 1'b0, 5'd16, 6'd0);
        #1;
        check64("idle_after_reset_busy", {63'd0, ex_busy}, 64'd0);
        step_expect(64'd7, 64'd4, 5'd16);

        // Branch resolution (no register write, so EX/MEM stays a bubble).
        set_nop();
        ex_branch    = 1'b1;
        ex_pc_plus4  = 64'h1000;
        ex_imm16     = 16'hFFFF;
        ex_reg_data1 = 64'd9;
        ex_reg_data2 = 64'd9;
        #1;
        check64("branch_taken_eq", {63'd0, ex_branch_taken}, 64'd1);
        check64("branch_target", ex_branch_target, 64'h0FFC);
        @(posedge clk);
        #1;
        ex_reg_data2 = 64'd10;
        #1;
        check64("branch_taken_ne", {63'd0, ex_branch_taken}, 64'd0);
        @(posedge clk);
        #1;

        set_nop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
